// File: rtl/ipi_send_queue.sv
// rtl/ipi_send_queue.sv - per-core IPI send FIFO and Wishbone write master.
// Each queued send (and/or pending IRQ ack) becomes one single-beat write to CONTROL.
module ipi_send_queue #(
  parameter int CORE_ID   = 0,
  parameter int NUM_CORES = 2,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [13:0]              req_dst,
  input  logic [15:0]              req_data,
  input  logic                     ack_req,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy,
  output logic                     err_o,
  input  logic                     err_clr,
  output logic [16:0]              wbm_adr_o,
  output logic [31:0]              wbm_dat_o,
  output logic [3:0]               wbm_sel_o,
  output logic                     wbm_we_o,
  output logic                     wbm_cyc_o,
  output logic                     wbm_stb_o,
  output logic [2:0]               wbm_cti_o,
  output logic [1:0]               wbm_bte_o,
  input  logic                     wbm_ack_i,
  input  logic                     wbm_err_i,
  input  logic                     wbm_rty_i
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [13:0]   NC       = 14'(NUM_CORES);
  localparam logic [7:0]    TMO      = 8'(TIMEOUT);

  typedef enum logic {S_IDLE, S_WRITE} state_t;
  state_t r_state, w_state_nxt;

  logic [29:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_ack_pending, r_err, r_cyc;
  logic [31:0]   r_dat;
  logic [7:0]    r_tmo;

  logic w_full, w_empty, w_accept, w_dst_ok, w_push, w_pop;
  logic w_start, w_done, w_fail, w_ack_clr, w_tmo_hit;

  assign w_full    = (r_level == LVL_FULL);
  assign w_empty   = (r_level == '0);
  assign w_dst_ok  = (req_dst < NC);
  assign w_accept  = req_valid & ~w_full;
  assign w_push    = w_accept & w_dst_ok;
  assign w_tmo_hit = (r_tmo == TMO);

  // Response priority inside a cycle: err > rty > ack > timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_fail      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty || r_ack_pending) begin
          w_start     = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wbm_err_i) begin
          w_fail      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (wbm_rty_i) begin
          w_state_nxt = S_IDLE;
        end else if (wbm_ack_i) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_tmo_hit) begin
          w_fail      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Completion only retires what the issued word actually carried.
  assign w_pop     = (w_done | w_fail) & r_dat[30];
  assign w_ack_clr = (w_done | w_fail) & r_dat[31];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cyc         <= 1'b0;
      r_dat         <= '0;
      r_tmo         <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_ack_pending <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= (w_state_nxt == S_WRITE);
      if (w_start) begin
        r_dat <= {r_ack_pending, ~w_empty, (w_empty ? 30'd0 : r_mem[r_rd_ptr])};
        r_tmo <= '0;
      end else if (r_state == S_WRITE) begin
        r_tmo <= r_tmo + 8'd1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (ack_req)        r_ack_pending <= 1'b1;
      else if (w_ack_clr) r_ack_pending <= 1'b0;
      if (w_fail || (w_accept && !w_dst_ok)) r_err <= 1'b1;
      else if (err_clr)                      r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {req_dst, req_data};
  end

  assign req_ready  = ~w_full;
  assign fifo_level = r_level;
  assign busy       = ~w_empty | r_ack_pending | r_cyc;
  assign err_o      = r_err;
  assign wbm_adr_o  = {14'(CORE_ID), 3'b000};
  assign wbm_dat_o  = r_dat;
  assign wbm_sel_o  = 4'hF;
  assign wbm_we_o   = r_cyc;
  assign wbm_cyc_o  = r_cyc;
  assign wbm_stb_o  = r_cyc;
  assign wbm_cti_o  = 3'b111;
  assign wbm_bte_o  = 2'b00;

endmodule

// File: tb/tb_ipi_send_queue.sv
// tb/tb_ipi_send_queue.sv - bench for ipi_send_queue: vectors, directed sequences, random vs queue model.
module tb_ipi_send_queue;

  localparam int DEPTH = 4, NUM_CORES = 2, TIMEOUT = 255;

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, ack_req = 1'b0, err_clr = 1'b0;
  logic ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;
  logic [13:0] req_dst = '0;
  logic [15:0] req_data = '0;
  logic req_ready, busy, err_o, wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0] fifo_level;
  logic [16:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0] wbm_sel_o;
  logic [2:0] wbm_cti_o;
  logic [1:0] wbm_bte_o;

  ipi_send_queue #(.CORE_ID(0), .NUM_CORES(NUM_CORES), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_dst(req_dst),
    .req_data(req_data), .ack_req(ack_req), .fifo_level(fifo_level), .busy(busy), .err_o(err_o),
    .err_clr(err_clr), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o),
    .wbm_bte_o(wbm_bte_o), .wbm_ack_i(ack_i), .wbm_err_i(err_i), .wbm_rty_i(rty_i)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  bit slv_ack = 0, slv_err = 0, slv_rty = 0;
  int cyc_cnt = 0;

  // Transaction-level reference: queue of sends, pending-ack bit, sticky error, issued word.
  logic [29:0] m_q[$];
  bit          m_ackp = 0, m_err = 0, m_wr = 0;
  logic [31:0] m_word = '0;
  int          m_cnt = 0;
  logic [31:0] starts[$], acks[$];

  typedef struct {
    logic        v;
    logic [13:0] dst;
    logic [15:0] data;
    logic        ack;
    logic        exp_cyc;
    logic [31:0] exp_dat;
    logic [2:0]  exp_lvl;
    logic        exp_busy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_model();
    chk("ready", req_ready, m_q.size() < DEPTH);
    chk("level", fifo_level, m_q.size());
    chk("err", err_o, m_err);
    chk("busy", busy, (m_q.size() != 0) || m_ackp || m_wr);
    chk("cyc", wbm_cyc_o, m_wr);
    chk("stb", wbm_stb_o, m_wr);
    chk("we", wbm_we_o, m_wr);
    if (m_wr) chk("dat", wbm_dat_o, m_word);
  endtask

  task automatic model_edge();
    bit acc, fail, done, popq, clrack;
    if (rst) begin
      m_q.delete(); m_ackp = 0; m_err = 0; m_wr = 0; m_word = '0; m_cnt = 0;
      return;
    end
    acc = req_valid && (m_q.size() < DEPTH);
    fail = 0; done = 0; popq = 0; clrack = 0;
    if (m_wr) begin
      if (err_i) fail = 1;
      else if (rty_i) m_wr = 0;
      else if (ack_i) done = 1;
      else if (m_cnt == TIMEOUT) fail = 1;
      else m_cnt++;
      if (fail || done) begin
        m_wr = 0;
        popq = m_word[30];
        clrack = m_word[31];
        if (done) acks.push_back(m_word);
      end
    end else if (m_q.size() != 0 || m_ackp) begin
      m_word = {m_ackp, m_q.size() != 0, (m_q.size() != 0) ? m_q[0] : 30'd0};
      m_wr = 1;
      m_cnt = 0;
      starts.push_back(m_word);
    end
    if (popq) void'(m_q.pop_front());
    if (acc && req_dst < NUM_CORES) m_q.push_back({req_dst, req_data});
    if (ack_req) m_ackp = 1;
    else if (clrack) m_ackp = 0;
    if (fail || (acc && req_dst >= NUM_CORES)) m_err = 1;
    else if (err_clr) m_err = 0;
  endtask

  task automatic step(input bit en);
    ack_i = wbm_cyc_o & slv_ack;
    err_i = wbm_cyc_o & slv_err;
    rty_i = wbm_cyc_o & slv_rty;
    if (en) check_model();
    if (wbm_cyc_o === 1'b1) cyc_cnt++;
    model_edge();
    @(posedge clk);
    #1;
    ack_req = 0;
    err_clr = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && busy !== 1'b0; k++) step(1);
    chk("idle_reached", busy, 0);
  endtask

  task automatic push(input logic [13:0] d, input logic [15:0] v);
    req_valid = 1; req_dst = d; req_data = v;
    step(1);
    req_valid = 0;
  endtask

  initial begin
    vec_t tbl[5];
    bit took;
    int guard;
    int r;

    rst = 1;
    step(0);
    step(1);
    rst = 0;
    chk("rst_dat", wbm_dat_o, 32'h0);
    chk("rst_adr", wbm_adr_o, 17'h00000);
    chk("rst_sel", wbm_sel_o, 4'hF);
    chk("rst_cti", wbm_cti_o, 3'b111);
    chk("rst_bte", wbm_bte_o, 2'b00);
    chk("rst_ready", req_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_err", err_o, 0);

    // Single send with one-cycle-ack slave
    tbl[0] = '{1'b1, 14'd1, 16'hBEEF, 1'b0, 1'b0, 32'h0,         3'd0, 1'b0};
    tbl[1] = '{1'b0, 14'd0, 16'h0,    1'b0, 1'b0, 32'h0,         3'd1, 1'b1};
    tbl[2] = '{1'b0, 14'd0, 16'h0,    1'b0, 1'b1, 32'h4001_BEEF, 3'd1, 1'b1};
    tbl[3] = '{1'b0, 14'd0, 16'h0,    1'b0, 1'b0, 32'h0,         3'd0, 1'b0};
    tbl[4] = '{1'b0, 14'd0, 16'h0,    1'b0, 1'b0, 32'h0,         3'd0, 1'b0};
    starts.delete(); acks.delete();
    slv_ack = 1;
    for (int i = 0; i < 5; i++) begin
      req_valid = tbl[i].v; req_dst = tbl[i].dst; req_data = tbl[i].data; ack_req = tbl[i].ack;
      chk("vec_cyc", wbm_cyc_o, tbl[i].exp_cyc);
      chk("vec_level", fifo_level, tbl[i].exp_lvl);
      chk("vec_busy", busy, tbl[i].exp_busy);
      if (tbl[i].exp_cyc) begin
        chk("vec_dat", wbm_dat_o, tbl[i].exp_dat);
        chk("vec_adr", wbm_adr_o, 17'h00000);
      end
      step(1);
    end
    req_valid = 0;
    chk("single_writes", acks.size(), 1);

    // Fill and drain with stalled slave
    starts.delete(); acks.delete();
    slv_ack = 0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1; req_dst = 14'(i % 2); req_data = 16'(i + 1);
      guard = 0;
      took = 0;
      while (!took && guard < 20) begin
        took = req_ready;
        if (i == 4 && guard == 0) chk("full_after_4", req_ready, 0);
        if (i == 4 && guard == 1) slv_ack = 1;
        step(1);
        guard++;
      end
      if (!took) chk("push_accepted", 0, 1);
    end
    req_valid = 0;
    slv_ack = 1;
    drain();
    chk("fill_writes", acks.size(), 5);
    chk("fill_starts", starts.size(), 5);
    for (int k = 0; k < 5 && k < acks.size(); k++) chk("fill_order", acks[k][15:0], k + 1);

    // Ack merge
    starts.delete(); acks.delete();
    slv_ack = 0;
    ack_req = 1;
    push(14'd0, 16'h1234);
    ack_req = 1;
    step(1);
    step(1);
    slv_ack = 1;
    drain();
    ack_req = 1;
    step(1);
    drain();
    chk("merge_writes", acks.size(), 2);
    chk("merge_first", acks[0], 32'hC000_1234);
    chk("merge_ackonly", acks[1], 32'h8000_0000);

    // Retry then ack
    starts.delete(); acks.delete();
    slv_ack = 0; slv_rty = 1;
    push(14'd1, 16'h5A5A);
    step(1);
    step(1);
    slv_rty = 0; slv_ack = 1;
    drain();
    chk("retry_starts", starts.size(), 2);
    chk("retry_word0", starts[0], 32'h4001_5A5A);
    chk("retry_word1", starts[1], 32'h4001_5A5A);
    chk("retry_acks", acks.size(), 1);
    chk("retry_err", err_o, 0);

    // Slave error, then clear
    starts.delete(); acks.delete();
    slv_ack = 0; slv_err = 1;
    push(14'd1, 16'h0BAD);
    drain();
    chk("err_flag", err_o, 1);
    chk("err_level", fifo_level, 0);
    chk("err_acks", acks.size(), 0);
    slv_err = 0;
    err_clr = 1;
    step(1);
    chk("err_cleared", err_o, 0);

    // Timeout with silent slave
    slv_ack = 0;
    push(14'd0, 16'h7777);
    cyc_cnt = 0;
    drain();
    chk("tmo_cycles", cyc_cnt, TIMEOUT + 1);
    chk("tmo_err", err_o, 1);
    chk("tmo_level", fifo_level, 0);
    err_clr = 1;
    step(1);

    // Invalid destination
    starts.delete();
    push(14'(NUM_CORES), 16'h1111);
    step(1); step(1); step(1);
    chk("inv_nowrite", starts.size(), 0);
    chk("inv_err", err_o, 1);
    chk("inv_level", fifo_level, 0);
    err_clr = 1;
    step(1);

    // Reset mid-WRITE
    slv_ack = 0;
    ack_req = 1;
    push(14'd0, 16'h2222);
    step(1);
    chk("pre_rst_cyc", wbm_cyc_o, 1);
    rst = 1;
    step(1);
    rst = 0;
    chk("rst_mid_cyc", wbm_cyc_o, 0);
    chk("rst_mid_level", fifo_level, 0);
    chk("rst_mid_busy", busy, 0);

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_dst = 14'($urandom_range(0, 2));
      req_data = 16'($urandom);
      ack_req = ($urandom_range(0, 7) == 0);
      err_clr = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 9);
      slv_ack = (r < 6); slv_rty = (r == 6); slv_err = (r == 7);
      step(1);
    end
    req_valid = 0;
    slv_ack = 1; slv_rty = 0; slv_err = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
